// File: rtl/line_fill_buffer.sv
// Line fill buffer: fetches one cache line critical-word-first with wrap-around,
// assembles it into a flat line register (word k at bits [32k+31:32k]) and
// signals early restart (critical word) and line completion.
module line_fill_buffer #(
  parameter int WORDS  = 32,
  parameter int WORD_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      fill_start,
  input  logic [ADDR_W-1:0]         fill_addr,
  input  logic                      flush,
  output logic                      busy,
  output logic                      mem_req,
  output logic [ADDR_W-1:0]         mem_addr,
  input  logic                      mem_ack,
  input  logic [WORD_W-1:0]         mem_rdata,
  output logic                      crit_valid,
  output logic [WORD_W-1:0]         crit_word,
  output logic [WORDS-1:0]          valid_mask,
  output logic [WORDS*WORD_W-1:0]   line_out,
  output logic                      line_valid
);

  localparam int LOG_W  = $clog2(WORDS);
  localparam int IDX_W  = (LOG_W > 0) ? LOG_W : 1;
  localparam int OFF_W  = LOG_W + 2;
  localparam int BASE_W = ADDR_W - OFF_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_DONE
  } state_t;

  state_t                     r_state;
  state_t                     w_next;
  logic [BASE_W-1:0]          r_base;
  logic [IDX_W-1:0]           r_crit;
  logic [IDX_W-1:0]           r_cnt;
  logic [IDX_W-1:0]           w_idx;
  logic [IDX_W-1:0]           w_crit_in;
  logic                       w_accept;
  logic                       w_ack;
  logic                       w_last;
  logic                       r_crit_valid;
  logic [WORD_W-1:0]          r_crit_word;
  logic [WORDS-1:0]           r_mask;
  logic [WORDS*WORD_W-1:0]    r_line;

  // A start is only taken outside REQ and never together with flush.
  assign w_accept = fill_start && !flush && (r_state != S_REQ);
  // Acks count only while requesting; an ack coinciding with flush is dropped.
  assign w_ack    = mem_ack && (r_state == S_REQ) && !flush;
  assign w_last   = (r_cnt == IDX_W'(WORDS - 1));
  // Wrapping add in IDX_W bits gives the critical-word-first order.
  assign w_idx    = r_crit + r_cnt;

  // Single-word lines have no index field in the address.
  generate
    if (LOG_W > 0) begin : g_idx
      assign w_crit_in = fill_addr[OFF_W-1:2];
      assign mem_addr  = {r_base, w_idx, 2'b00};
    end else begin : g_noidx
      assign w_crit_in = '0;
      assign mem_addr  = {r_base, 2'b00};
    end
  endgenerate

  assign crit_valid = r_crit_valid;
  assign crit_word  = r_crit_word;
  assign valid_mask = r_mask;
  assign line_out   = r_line;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic and state-decoded outputs; flush wins over everything.
  always_comb begin
    w_next     = r_state;
    busy       = 1'b0;
    mem_req    = 1'b0;
    line_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_next = S_REQ;
      end
      S_REQ: begin
        busy    = 1'b1;
        mem_req = 1'b1;
        if (w_ack && w_last) w_next = S_DONE;
      end
      S_DONE: begin
        line_valid = 1'b1;
        w_next     = w_accept ? S_REQ : S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    if (flush) w_next = S_IDLE;
  end

  // Fill datapath: request address, word counter, line assembly, critical word.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_base       <= '0;
      r_crit       <= '0;
      r_cnt        <= '0;
      r_crit_valid <= 1'b0;
      r_crit_word  <= '0;
      r_mask       <= '0;
      r_line       <= '0;
    end else begin
      r_crit_valid <= 1'b0;
      if (flush) begin
        r_cnt  <= '0;
        r_mask <= '0;
      end else if (w_accept) begin
        r_base <= fill_addr[ADDR_W-1:OFF_W];
        r_crit <= w_crit_in;
        r_cnt  <= '0;
        r_mask <= '0;
      end else if (w_ack) begin
        for (int unsigned k = 0; k < WORDS; k++) begin
          if (w_idx == IDX_W'(k)) begin
            r_line[k*WORD_W +: WORD_W] <= mem_rdata;
            r_mask[k]                  <= 1'b1;
          end
        end
        r_cnt <= r_cnt + IDX_W'(1);
        if (r_cnt == '0) begin
          r_crit_word  <= mem_rdata;
          r_crit_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_line_fill_buffer.sv
// Scenario-based bench for line_fill_buffer: expected request addresses and
// critical words are queued when a fill is started and consumed as the DUT
// issues requests / pulses crit_valid; the assembled line is tracked per word.
module tb_line_fill_buffer;

  logic           clk;
  logic           reset;
  logic           fill_start;
  logic [31:0]    fill_addr;
  logic           flush;
  logic           busy;
  logic           mem_req;
  logic [31:0]    mem_addr;
  logic           mem_ack;
  logic [31:0]    mem_rdata;
  logic           crit_valid;
  logic [31:0]    crit_word;
  logic [31:0]    valid_mask;
  logic [1023:0]  line_out;
  logic           line_valid;

  int unsigned    n_tests;
  int unsigned    n_fail;
  logic [31:0]    q_addr[$];
  logic [31:0]    q_crit[$];
  logic [31:0]    exp_line [32];
  logic [31:0]    exp_mask;

  line_fill_buffer #(.WORDS(32), .WORD_W(32), .ADDR_W(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .fill_start (fill_start),
    .fill_addr  (fill_addr),
    .flush      (flush),
    .busy       (busy),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .crit_valid (crit_valid),
    .crit_word  (crit_word),
    .valid_mask (valid_mask),
    .line_out   (line_out),
    .line_valid (line_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1023:0] pack_line();
    logic [1023:0] v;
    v = '0;
    for (int k = 0; k < 32; k++) v[k*32 +: 32] = exp_line[k];
    return v;
  endfunction

  task automatic check_line(input string name);
    logic [1023:0] e;
    e = pack_line();
    n_tests++;
    if (line_out !== e) begin
      n_fail++;
      for (int k = 0; k < 32; k++) begin
        if (line_out[k*32 +: 32] !== e[k*32 +: 32]) begin
          $display("FAIL %s word %0d: got %h expected %h", name, k,
                   line_out[k*32 +: 32], e[k*32 +: 32]);
          break;
        end
      end
    end
  endtask

  // Complete fill with 'waits' idle cycles before each ack; word k data = dbase+k.
  // Returns with the DONE cycle current.
  task automatic run_fill(input logic [31:0] addr, input int unsigned waits,
                          input logic [31:0] dbase, input bit poke_busy);
    logic [4:0]  crit;
    logic [4:0]  idx;
    logic [31:0] ea;
    logic [31:0] d;
    logic [31:0] ec;
    bit          exp_cv;
    int unsigned cyc;
    crit = addr[6:2];
    for (int n = 0; n < 32; n++) begin
      idx = crit + 5'(n);
      q_addr.push_back({addr[31:7], idx, 2'b00});
    end
    q_crit.push_back(dbase + {27'd0, crit});
    exp_mask = '0;
    fill_start = 1'b1;
    fill_addr  = addr;
    tick();
    fill_start = 1'b0;
    fill_addr  = 32'h0;
    cyc = 1;
    for (int n = 0; n < 32; n++) begin
      ea = q_addr.pop_front();
      for (int unsigned w = 0; w <= waits; w++) begin
        n_tests++;
        if (mem_req !== 1'b1 || busy !== 1'b1 || line_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL fill_req n=%0d: req=%b busy=%b lv=%b expected 1 1 0", n, mem_req, busy, line_valid);
        end
        n_tests++;
        if (mem_addr !== ea) begin
          n_fail++;
          $display("FAIL fill_addr n=%0d w=%0d: got %h expected %h", n, w, mem_addr, ea);
        end
        exp_cv = (n == 1 && w == 0);
        n_tests++;
        if (crit_valid !== exp_cv) begin
          n_fail++;
          $display("FAIL crit_valid n=%0d w=%0d: got %b expected %b", n, w, crit_valid, exp_cv);
        end
        if (exp_cv) begin
          ec = q_crit.pop_front();
          n_tests++;
          if (crit_word !== ec) begin
            n_fail++;
            $display("FAIL crit_word: got %h expected %h", crit_word, ec);
          end
        end
        if (w == waits) begin
          idx = ea[6:2];
          d   = dbase + {27'd0, idx};
          mem_ack   = 1'b1;
          mem_rdata = d;
          exp_line[idx] = d;
          exp_mask[idx] = 1'b1;
          if (poke_busy && n == 5) begin
            fill_start = 1'b1;
            fill_addr  = 32'hDEAD_BE00;
          end
        end
        tick();
        mem_ack    = 1'b0;
        mem_rdata  = 32'h0;
        fill_start = 1'b0;
        fill_addr  = 32'h0;
        cyc++;
        n_tests++;
        if (valid_mask !== exp_mask) begin
          n_fail++;
          $display("FAIL valid_mask n=%0d: got %h expected %h", n, valid_mask, exp_mask);
        end
      end
    end
    n_tests++;
    if (line_valid !== 1'b1 || mem_req !== 1'b0 || busy !== 1'b0 || crit_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL done_flags: lv=%b req=%b busy=%b cv=%b expected 1 0 0 0", line_valid, mem_req, busy, crit_valid);
    end
    n_tests++;
    if (cyc != 32 * (waits + 1) + 1) begin
      n_fail++;
      $display("FAIL done_latency: got %0d expected %0d", cyc, 32 * (waits + 1) + 1);
    end
    check_line("done_line");
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    n_tests++;
    if ({busy, mem_req, crit_valid, line_valid} !== 4'b0000 || mem_addr !== 32'h0 ||
        crit_word !== 32'h0 || valid_mask !== 32'h0 || line_out !== '0) begin
      n_fail++;
      $display("FAIL reset_state: flags=%b addr=%h cw=%h mask=%h expected all 0",
               {busy, mem_req, crit_valid, line_valid}, mem_addr, crit_word, valid_mask);
    end
    reset = 1'b0;
    for (int k = 0; k < 32; k++) exp_line[k] = 32'h0;
  endtask

  task automatic test_linear();
    run_fill(32'h0000_1000, 0, 32'hA000_0000, 1'b0);
    n_tests++;
    if (line_out[31*32 +: 32] !== 32'hA000_001F) begin
      n_fail++;
      $display("FAIL linear_word31: got %h expected a000001f", line_out[31*32 +: 32]);
    end
    tick();
    n_tests++;
    if (line_valid !== 1'b0 || busy !== 1'b0 || valid_mask !== 32'hFFFF_FFFF) begin
      n_fail++;
      $display("FAIL linear_idle: lv=%b busy=%b mask=%h expected 0 0 ffffffff", line_valid, busy, valid_mask);
    end
  endtask

  task automatic test_wrap();
    run_fill(32'h0000_2078, 0, 32'hB000_0000, 1'b0);
    tick();
  endtask

  task automatic test_waits();
    run_fill(32'h0000_4010, 3, 32'hC000_0000, 1'b0);
    tick();
  endtask

  task automatic test_flush();
    fill_start = 1'b1;
    fill_addr  = 32'h0000_3000;
    tick();
    fill_start = 1'b0;
    for (int n = 0; n < 10; n++) begin
      n_tests++;
      if (mem_addr !== 32'h0000_3000 + 32'(4 * n)) begin
        n_fail++;
        $display("FAIL flush_addr n=%0d: got %h expected %h", n, mem_addr, 32'h0000_3000 + 32'(4 * n));
      end
      mem_ack   = 1'b1;
      mem_rdata = 32'hD000_0000 + 32'(n);
      exp_line[n] = mem_rdata;
      tick();
    end
    mem_ack    = 1'b1;
    mem_rdata  = 32'hBAD0_BAD0;
    flush      = 1'b1;
    fill_start = 1'b1;
    fill_addr  = 32'h0000_7000;
    tick();
    mem_ack    = 1'b0;
    flush      = 1'b0;
    fill_start = 1'b0;
    fill_addr  = 32'h0;
    n_tests++;
    if (mem_req !== 1'b0 || busy !== 1'b0 || valid_mask !== 32'h0) begin
      n_fail++;
      $display("FAIL flush_state: req=%b busy=%b mask=%h expected 0 0 0", mem_req, busy, valid_mask);
    end
    for (int c = 0; c < 4; c++) begin
      n_tests++;
      if (line_valid !== 1'b0 || crit_valid !== 1'b0 || mem_req !== 1'b0) begin
        n_fail++;
        $display("FAIL flush_quiet c=%0d: lv=%b cv=%b req=%b expected 0 0 0", c, line_valid, crit_valid, mem_req);
      end
      tick();
    end
    check_line("flush_line");
  endtask

  task automatic test_ignored();
    mem_ack   = 1'b1;
    mem_rdata = 32'hFFFF_FFFF;
    tick();
    tick();
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    n_tests++;
    if (valid_mask !== 32'h0 || mem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_ack: mask=%h req=%b expected 0 0", valid_mask, mem_req);
    end
    check_line("idle_ack_line");
    run_fill(32'h0000_8044, 1, 32'hE000_0000, 1'b1);
    tick();
  endtask

  task automatic test_done_restart();
    run_fill(32'h0000_5000, 0, 32'hF000_0000, 1'b0);
    fill_start = 1'b1;
    fill_addr  = 32'h0000_6040;
    tick();
    fill_start = 1'b0;
    fill_addr  = 32'h0;
    n_tests++;
    if (mem_req !== 1'b1 || busy !== 1'b1 || valid_mask !== 32'h0 || line_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL restart_state: req=%b busy=%b mask=%h lv=%b expected 1 1 0 0", mem_req, busy, valid_mask, line_valid);
    end
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if (mem_addr !== 32'h0000_6040 + 32'(4 * k)) begin
        n_fail++;
        $display("FAIL restart_addr k=%0d: got %h expected %h", k, mem_addr, 32'h0000_6040 + 32'(4 * k));
      end
      mem_ack   = 1'b1;
      mem_rdata = 32'h1234_0000 + 32'(k);
      tick();
    end
    mem_ack = 1'b0;
    n_tests++;
    if (valid_mask !== 32'h0007_0000) begin
      n_fail++;
      $display("FAIL restart_mask: got %h expected 00070000", valid_mask);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_tests++;
    if ({busy, mem_req, crit_valid, line_valid} !== 4'b0000 || mem_addr !== 32'h0 ||
        crit_word !== 32'h0 || valid_mask !== 32'h0 || line_out !== '0) begin
      n_fail++;
      $display("FAIL midfill_reset: flags=%b addr=%h cw=%h mask=%h expected all 0",
               {busy, mem_req, crit_valid, line_valid}, mem_addr, crit_word, valid_mask);
    end
  endtask

  initial begin
    n_tests    = 0;
    n_fail     = 0;
    reset      = 1'b1;
    fill_start = 1'b0;
    fill_addr  = 32'h0;
    flush      = 1'b0;
    mem_ack    = 1'b0;
    mem_rdata  = 32'h0;
    exp_mask   = '0;
    test_reset();
    test_linear();
    test_wrap();
    test_waits();
    test_flush();
    test_ignored();
    test_done_restart();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
